// File: rtl/cmsdk_ahb_bm_output_arb_qos_if.sv
// rtl/cmsdk_ahb_bm_output_arb_qos_if.sv - request/grant bundle of the bus matrix QoS output arbiter
// Purpose: groups the four per-port requests and static priorities, the slave-side AHB
//          control of the current output transfer, and the registered grant outputs.
// Ports:   none (signal bundle only)
//          modport slave  - arbiter view: requests/priorities/AHB control in, grant out
//          modport master - driving side: requests/priorities/AHB control out, grant in
interface cmsdk_ahb_bm_output_arb_qos_if;
  logic       req_port0;
  logic       req_port1;
  logic       req_port2;
  logic       req_port3;
  logic [1:0] prio_port0;
  logic [1:0] prio_port1;
  logic [1:0] prio_port2;
  logic [1:0] prio_port3;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;

  modport slave (
    input  req_port0, req_port1, req_port2, req_port3,
    input  prio_port0, prio_port1, prio_port2, prio_port3,
    input  HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port
  );

  modport master (
    output req_port0, req_port1, req_port2, req_port3,
    output prio_port0, prio_port1, prio_port2, prio_port3,
    output HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port
  );
endinterface

// File: rtl/cmsdk_ahb_bm_output_arb_qos.sv
// rtl/cmsdk_ahb_bm_output_arb_qos.sv - 4-input QoS output-stage arbiter for an AHB bus matrix slave port
// Purpose: picks which input stage drives the shared slave using static priority, round-robin
//          tie-break and per-port aging; never switches inside a locked sequence or fixed burst.
// Ports:   HCLK     - AHB clock
//          HRESETn  - asynchronous active-low reset
//          bus      - slave modport: req/prio per port, HREADYM/HSELM/HTRANSM/HBURSTM/HMASTLOCKM in,
//                     registered addr_in_port/no_port out
module cmsdk_ahb_bm_output_arb_qos #(
  parameter int AGE_W     = 4,
  parameter int AGE_LIMIT = 8
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  cmsdk_ahb_bm_output_arb_qos_if.slave       bus
);

  localparam logic [1:0]       TR_IDLE   = 2'b00;
  localparam logic [1:0]       TR_NONSEQ = 2'b10;
  localparam logic [1:0]       TR_SEQ    = 2'b11;
  localparam logic [AGE_W-1:0] LP_LIMIT  = AGE_W'(AGE_LIMIT);
  localparam logic [AGE_W-1:0] LP_ONE    = AGE_W'(1);
  localparam logic [AGE_W-1:0] LP_MAX    = '1;

  logic [1:0]       r_addr;
  logic             r_no_port;
  logic [3:0]       r_burst_remain;
  logic             r_burst_hold;
  logic [AGE_W-1:0] r_age [4];

  logic [3:0] w_next_remain;
  logic       w_next_hold;
  logic [3:0] w_req;
  logic [1:0] w_prio [4];
  logic [1:0] w_eff  [4];
  logic [1:0] w_max;
  logic [1:0] w_start;
  logic [1:0] w_idx;
  logic [1:0] w_win;
  logic       w_found;
  logic [1:0] w_next_addr;
  logic       w_next_no;

  assign w_req     = {bus.req_port3, bus.req_port2, bus.req_port1, bus.req_port0};
  assign w_prio[0] = bus.prio_port0;
  assign w_prio[1] = bus.prio_port1;
  assign w_prio[2] = bus.prio_port2;
  assign w_prio[3] = bus.prio_port3;

  assign bus.addr_in_port = r_addr;
  assign bus.no_port      = r_no_port;

  // Beats still owed by the current fixed-length burst, counted as of the next cycle.
  // BUSY falls through to the default and leaves the count untouched.
  always_comb begin
    w_next_remain = r_burst_remain;
    if (!bus.HSELM || bus.HTRANSM == TR_IDLE) begin
      w_next_remain = 4'd0;
    end else if (bus.HTRANSM == TR_NONSEQ) begin
      case (bus.HBURSTM)
        3'd2, 3'd3: w_next_remain = 4'd3;
        3'd4, 3'd5: w_next_remain = 4'd7;
        3'd6, 3'd7: w_next_remain = 4'd15;
        default:    w_next_remain = 4'd0;
      endcase
    end else if (bus.HTRANSM == TR_SEQ) begin
      w_next_remain = (r_burst_remain == 4'd0) ? 4'd0 : r_burst_remain - 4'd1;
    end
  end

  assign w_next_hold = (w_next_remain != 4'd0);

  // Winner: highest effective priority; ties resolved by scanning upward from the port
  // after the current one (from port 0 when nothing is selected).
  always_comb begin
    w_max   = 2'd0;
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int n = 0; n < 4; n++) begin
      w_eff[n] = (r_age[n] >= LP_LIMIT) ? 2'd3 : w_prio[n];
    end
    for (int n = 0; n < 4; n++) begin
      if (w_req[n] && w_eff[n] > w_max) w_max = w_eff[n];
    end
    w_start = r_no_port ? 2'd0 : r_addr + 2'd1;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_start + 2'(k);
      if (!w_found && w_req[w_idx] && w_eff[w_idx] == w_max) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_next_addr = r_addr;
    w_next_no   = r_no_port;
    if (!bus.HMASTLOCKM && !w_next_hold) begin
      if (|w_req) begin
        w_next_addr = w_win;
        w_next_no   = 1'b0;
      end else if (r_no_port || !bus.HSELM) begin
        // Nobody asking: drop the port unless it still owns an active slave transfer.
        w_next_no = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr         <= 2'd0;
      r_no_port      <= 1'b1;
      r_burst_remain <= 4'd0;
      r_burst_hold   <= 1'b0;
      for (int n = 0; n < 4; n++) r_age[n] <= '0;
    end else if (bus.HREADYM) begin
      r_addr         <= w_next_addr;
      r_no_port      <= w_next_no;
      r_burst_remain <= w_next_remain;
      r_burst_hold   <= w_next_hold;
      // A port stops aging once it is idle or is the one being granted next.
      for (int n = 0; n < 4; n++) begin
        if (!w_req[n] || (!w_next_no && w_next_addr == 2'(n))) begin
          r_age[n] <= '0;
        end else if (r_age[n] != LP_MAX) begin
          r_age[n] <= r_age[n] + LP_ONE;
        end
      end
    end
  end

endmodule
